// File: rtl/add_round_key_stream.sv
// Streaming AES AddRoundKey stage: a bank of round keys XORed onto state beats by
// per-block round index, with a registered output and a one-entry skid buffer.
module ark_lane (
  input  logic [7:0] state,
  input  logic [7:0] key,
  output logic [7:0] res
);
  assign res = state ^ key;
endmodule

module add_round_key_stream #(
  parameter  int DATA_W   = 128,
  parameter  int NUM_KEYS = 11,
  localparam int RW       = $clog2(NUM_KEYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              key_we,
  input  logic [RW-1:0]     key_waddr,
  input  logic [DATA_W-1:0] key_wdata,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [RW-1:0]     out_round,
  output logic              out_last,
  output logic              err_overrun
);
  localparam int          NUM_LANES = DATA_W / 8;
  localparam logic [RW:0] KEY_LIM   = (RW+1)'(NUM_KEYS);
  localparam logic [RW-1:0] LAST_RND = RW'(NUM_KEYS - 1);

  logic [DATA_W-1:0] bank [NUM_KEYS];
  logic [RW-1:0]     cnt;
  logic [NUM_LANES-1:0][7:0] key_sel, state_in, xor_res;

  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [RW-1:0]     skid_round;
  logic              skid_last;

  logic acc, out_free;

  assign in_ready = ~skid_valid;
  assign acc      = in_valid & in_ready;
  assign out_free = ~out_valid | out_ready;
  assign key_sel  = bank[cnt];
  assign state_in = in_data;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    ark_lane u_lane (.state(state_in[g]), .key(key_sel[g]), .res(xor_res[g]));
  end

  // Bank reads use the pre-edge value, so a same-cycle write affects only later beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_KEYS; i++) bank[i] <= '0;
    end else if (key_we && ({1'b0, key_waddr} < KEY_LIM)) begin
      bank[key_waddr] <= key_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      err_overrun <= 1'b0;
    end else if (clr) begin
      cnt         <= '0;
      err_overrun <= 1'b0;
    end else if (acc) begin
      if (in_last) begin
        cnt <= '0;
      end else if (cnt == LAST_RND) begin
        cnt         <= '0;
        err_overrun <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Output register refills from skid first; a new beat parks in skid only while the output stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_round  <= '0;
      out_last   <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_round <= '0;
      skid_last  <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        out_round  <= skid_round;
        out_last   <= skid_last;
        skid_valid <= 1'b0;
      end else if (acc) begin
        out_valid <= 1'b1;
        out_data  <= xor_res;
        out_round <= cnt;
        out_last  <= in_last;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (acc) begin
      skid_valid <= 1'b1;
      skid_data  <= xor_res;
      skid_round <= cnt;
      skid_last  <= in_last;
    end
  end
endmodule

// File: tb/tb_add_round_key_stream.sv
// Bench for add_round_key_stream: directed scenarios plus random traffic against a
// queue-based model of the in-flight beats, bank and round counter.
module tb_add_round_key_stream;
  localparam int DW = 128;
  localparam int NK = 11;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic          key_we = 1'b0;
  logic [RW-1:0] key_waddr = '0;
  logic [DW-1:0] key_wdata = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [RW-1:0] out_round;
  logic          out_last;
  logic          err_overrun;

  add_round_key_stream #(.DATA_W(DW), .NUM_KEYS(NK)) dut (
    .clk(clk), .rst(rst), .clr(clr), .key_we(key_we), .key_waddr(key_waddr),
    .key_wdata(key_wdata), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_round(out_round), .out_last(out_last), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    int            r;
    logic          l;
  } beat_t;

  beat_t         q[$];
  logic [DW-1:0] bank_m [NK];
  int            cnt_m;
  logic          err_m;
  int            n_pass = 0;
  int            n_total = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < NK; i++) bank_m[i] = '0;
    cnt_m = 0;
    err_m = 1'b0;
  endtask

  // Check the current registered outputs against the model, then advance one edge.
  task automatic tick();
    bit acc, drn;
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("out_data", out_data, q[0].d);
      chk("out_round", out_round, q[0].r);
      chk("out_last", out_last, q[0].l);
    end
    chk("err_overrun", err_overrun, err_m);
    acc = in_valid && (q.size() < 2);
    drn = (q.size() > 0) && out_ready;
    if (drn) void'(q.pop_front());
    if (acc) q.push_back('{in_data ^ bank_m[cnt_m], cnt_m, in_last});
    if (clr) begin
      cnt_m = 0;
      err_m = 1'b0;
    end else if (acc) begin
      if (in_last) cnt_m = 0;
      else if (cnt_m == NK - 1) begin cnt_m = 0; err_m = 1'b1; end
      else cnt_m++;
    end
    if (key_we && key_waddr < NK) bank_m[key_waddr] = key_wdata;
    @(posedge clk); #1;
  endtask

  task automatic load_key(input int a, input logic [DW-1:0] v);
    key_we = 1'b1; key_waddr = RW'(a); key_wdata = v;
    tick();
    key_we = 1'b0;
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic l);
    in_valid = 1'b1; in_data = d; in_last = l;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] kb;
    model_reset();
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_round", out_round, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_err", err_overrun, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1; rst = 1'b1;

    // single beat with bank[0] = 0F..0F
    load_key(0, {16{8'h0F}});
    beat({16{8'hFF}}, 1'b1);
    chk("first_beat_data", out_data, {16{8'hF0}});
    chk("first_beat_valid", out_valid, 1);
    tick();

    // full block back-to-back, bank[k] = k replicated
    for (int k = 0; k < NK; k++) begin
      kb = 8'(k);
      load_key(k, {16{kb}});
    end
    for (int k = 0; k < NK; k++) begin
      in_valid = 1'b1; in_data = '0; in_last = (k == NK - 1);
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();

    // backpressure: two beats taken, then in_ready drops
    out_ready = 1'b0;
    in_valid = 1'b1; in_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    clr = 1'b1; tick(); clr = 1'b0;

    // overrun: 12 beats without last
    for (int i = 0; i < NK + 1; i++) begin
      in_valid = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom}; in_last = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    chk("overrun_sticky", err_overrun, 1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("overrun_cleared", err_overrun, 0);

    // key write to bank[2] coincident with a round-2 beat
    beat('0, 1'b0);
    beat('0, 1'b0);
    key_we = 1'b1; key_waddr = 4'd2; key_wdata = {16{8'hA5}};
    beat('0, 1'b1);
    key_we = 1'b0;
    chk("old_key_used", out_data, {16{8'h02}});
    beat('0, 1'b0);
    beat('0, 1'b0);
    beat('0, 1'b1);
    chk("new_key_used", out_data, {16{8'hA5}});
    repeat (2) tick();

    // random traffic, including clr, out-of-range key writes and stalls
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      in_last   = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 40) == 0);
      key_we    = ($urandom_range(0, 9) == 0);
      key_waddr = RW'($urandom_range(0, 15));
      key_wdata = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    key_we = 1'b0; clr = 1'b0;

    // reset with beats in output and skid
    out_ready = 1'b0; in_valid = 1'b1; in_last = 1'b0;
    repeat (3) tick();
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    model_reset();
    @(posedge clk); #1; rst = 1'b1;
    out_ready = 1'b1;
    beat({16{8'h3C}}, 1'b1);
    chk("bank_zero_after_rst", out_data, {16{8'h3C}});
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
